piso_serializer_32_bit: RTL

- Parallel-in, serial-out serializer with valid/ready handshake on the parallel side.
- Sits directly upstream of the 32-bit SIPO shift register.
- Drives that register's Serial_Data_In and Shift_Data_Signal_In pins, so a word accepted here reappears intact on the SIPO Parallel_Data_Out after DATA_WIDTH shift cycles.
- Bits go out MSB first, which matches the SIPO left-shift ({reg[30:0], in}).

---
 rtl/piso_serializer_32_bit_if.sv | 36 +++
 rtl/piso_serializer_32_bit.sv | 90 +++++++++
 2 files changed

// File: rtl/piso_serializer_32_bit_if.sv
// Parallel-side handshake and serial-side outputs of the PISO serializer.
// The master modport is the upstream producer; the slave modport is the serializer itself.
interface piso_serializer_32_bit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Enable_In;
    logic [DATA_WIDTH-1:0] Parallel_Data_In;
    logic                  Data_Valid_In;
    logic                  Data_Ready_Out;
    logic                  Serial_Data_Out;
    logic                  Shift_Data_Signal_Out;
    logic                  Word_Done_Out;
    logic                  Busy_Out;

    modport master (
        output Enable_In,
        output Parallel_Data_In,
        output Data_Valid_In,
        input  Data_Ready_Out,
        input  Serial_Data_Out,
        input  Shift_Data_Signal_Out,
        input  Word_Done_Out,
        input  Busy_Out
    );

    modport slave (
        input  Enable_In,
        input  Parallel_Data_In,
        input  Data_Valid_In,
        output Data_Ready_Out,
        output Serial_Data_Out,
        output Shift_Data_Signal_Out,
        output Word_Done_Out,
        output Busy_Out
    );
endinterface

// File: rtl/piso_serializer_32_bit.sv
// Parallel-in serial-out serializer, MSB first, feeding a left-shifting SIPO register.
// Optional forced idle gap between words; GAP_CYCLES = 0 streams words back to back.
module piso_serializer_32_bit #(
    parameter int DATA_WIDTH = 32,
    parameter int GAP_CYCLES = 0
) (
    input logic                     Clk_In,
    input logic                     Reset_In,
    piso_serializer_32_bit_if.slave ser
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam bit GAPLESS = (GAP_CYCLES == 0);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t                r_State;
    logic [DATA_WIDTH-1:0] r_Shift;
    logic [CNT_W-1:0]      r_Count;
    logic [GAP_W-1:0]      r_Gap;

    logic last_bit;
    logic transfer;

    assign last_bit = (r_State == ST_SHIFT) && (r_Count == LAST_COUNT);

    // Ready is also masked by reset so nothing upstream sees a ready while reset is held.
    assign ser.Data_Ready_Out = Reset_In & ser.Enable_In &
                                ((r_State == ST_IDLE) | (last_bit & GAPLESS));
    assign ser.Shift_Data_Signal_Out = ser.Enable_In & (r_State == ST_SHIFT);
    assign ser.Serial_Data_Out       = (r_State == ST_SHIFT) ? r_Shift[DATA_WIDTH-1] : 1'b0;
    assign ser.Word_Done_Out         = ser.Enable_In & last_bit;
    assign ser.Busy_Out              = (r_State != ST_IDLE);

    assign transfer = ser.Data_Valid_In & ser.Data_Ready_Out;

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            r_State <= ST_IDLE;
            r_Shift <= '0;
            r_Count <= '0;
            r_Gap   <= '0;
        end else if (ser.Enable_In) begin
            case (r_State)
                ST_IDLE: begin
                    if (transfer) begin
                        r_Shift <= ser.Parallel_Data_In;
                        r_Count <= '0;
                        r_State <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_Count != LAST_COUNT) begin
                        r_Shift <= {r_Shift[DATA_WIDTH-2:0], 1'b0};
                        r_Count <= r_Count + CNT_W'(1);
                    end else if (GAPLESS) begin
                        // Reloading on the last bit keeps a held-valid stream free of bubbles.
                        if (transfer) begin
                            r_Shift <= ser.Parallel_Data_In;
                            r_Count <= '0;
                        end else begin
                            r_State <= ST_IDLE;
                        end
                    end else begin
                        r_Gap   <= GAP_LOAD;
                        r_State <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_Gap == '0) begin
                        r_State <= ST_IDLE;
                    end else begin
                        r_Gap <= r_Gap - GAP_W'(1);
                    end
                end
                default: begin
                    r_State <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
